// File: rtl/cpv3_rbcp_pkg.sv
// Shared RBCP register map, status bit positions and DAC commit FSM state type
// for the CPV3 RBCP responder.
package cpv3_rbcp_pkg;

    localparam logic [7:0] OFS_DAQ_STATE     = 8'h00;
    localparam logic [7:0] OFS_DAC_B3        = 8'h01;
    localparam logic [7:0] OFS_DAC_B2        = 8'h02;
    localparam logic [7:0] OFS_DAC_B1        = 8'h03;
    localparam logic [7:0] OFS_DAC_B0        = 8'h04;
    localparam logic [7:0] OFS_DAC_COMMIT    = 8'h05;
    localparam logic [7:0] OFS_ROW_START_HI  = 8'h06;
    localparam logic [7:0] OFS_ROW_START_LO  = 8'h07;
    localparam logic [7:0] OFS_ROW_END_HI    = 8'h08;
    localparam logic [7:0] OFS_ROW_END_LO    = 8'h09;
    localparam logic [7:0] OFS_COL_START_HI  = 8'h0A;
    localparam logic [7:0] OFS_COL_START_LO  = 8'h0B;
    localparam logic [7:0] OFS_COL_END_HI    = 8'h0C;
    localparam logic [7:0] OFS_COL_END_LO    = 8'h0D;
    localparam logic [7:0] OFS_PIX_SEL       = 8'h0E;
    localparam logic [7:0] OFS_POWER_ON_WAIT = 8'h0F;
    localparam logic [7:0] OFS_READ_PERIOD   = 8'h10;
    localparam logic [7:0] OFS_RST_PERIOD    = 8'h11;
    localparam logic [7:0] OFS_CLAMP_PERIOD  = 8'h12;
    localparam logic [7:0] OFS_STATUS        = 8'h13;
    localparam logic [7:0] OFS_ID            = 8'h14;

    localparam int unsigned STAT_BUSY_BIT = 0;
    localparam int unsigned STAT_PEND_BIT = 1;

    typedef enum logic [1:0] {
        DAC_IDLE  = 2'd0,
        DAC_PEND  = 2'd1,
        DAC_PULSE = 2'd2
    } dac_state_e;

    function automatic logic [7:0] status_byte(input logic busy, input logic pend);
        logic [7:0] s;
        s                = 8'h00;
        s[STAT_BUSY_BIT] = busy;
        s[STAT_PEND_BIT] = pend;
        return s;
    endfunction

endpackage

// File: rtl/rbcp_dac_commit.sv
// DAC commit sequencer: snapshots the staged DAC word on commit, waits for the
// serializer to go idle, then issues a single DAC_WE pulse.
module rbcp_dac_commit
    import cpv3_rbcp_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        commit_i,
    input  logic        dac_busy_i,
    input  logic [31:0] stage_i,
    output logic [31:0] dac_data_o,
    output logic        dac_we_o,
    output logic        pending_o
);

    dac_state_e  state_q;
    logic [31:0] dac_data_q;
    logic        dac_we_q;

    // Commit FSM; commits arriving in PEND or PULSE are absorbed without a new snapshot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= DAC_IDLE;
            dac_data_q <= 32'h0000_0000;
            dac_we_q   <= 1'b0;
        end else begin
            dac_we_q <= 1'b0;
            case (state_q)
                DAC_IDLE: begin
                    if (commit_i) begin
                        dac_data_q <= stage_i;
                        if (!dac_busy_i) begin
                            state_q  <= DAC_PULSE;
                            dac_we_q <= 1'b1;
                        end else begin
                            state_q <= DAC_PEND;
                        end
                    end
                end
                DAC_PEND: begin
                    if (!dac_busy_i) begin
                        state_q  <= DAC_PULSE;
                        dac_we_q <= 1'b1;
                    end
                end
                DAC_PULSE: state_q <= DAC_IDLE;
                default:   state_q <= DAC_IDLE;
            endcase
        end
    end

    assign dac_data_o = dac_data_q;
    assign dac_we_o   = dac_we_q;
    assign pending_o  = (state_q == DAC_PEND);

endmodule

// File: rtl/rbcp_responder.sv
// SiTCP RBCP slave: address decode, control register bank and read path.
// Optional macro RBCP_READBACK_EN enables read-back of the writable registers.
module rbcp_responder
    import cpv3_rbcp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [7:0]  ID_VALUE  = 8'hC3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        RBCP_ACT,
    input  logic [31:0] RBCP_ADDR,
    input  logic        RBCP_WE,
    input  logic        RBCP_RE,
    input  logic [7:0]  RBCP_WD,
    output logic        RBCP_ACK,
    output logic [7:0]  RBCP_RD,
    input  logic        DAC_BUSY,
    output logic [31:0] DAC_DATA,
    output logic        DAC_WE,
    output logic [7:0]  DAQ_STATE,
    output logic [7:0]  PIX_SEL,
    output logic [7:0]  POWER_ON_WAIT,
    output logic [7:0]  READ_PERIOD,
    output logic [7:0]  RST_PERIOD,
    output logic [7:0]  CLAMP_PERIOD,
    output logic [15:0] ROW_START,
    output logic [15:0] ROW_END,
    output logic [15:0] COL_START,
    output logic [15:0] COL_END
);

    logic        strobe_s;
    logic        in_win_s;
    logic        wr_en_s;
    logic        rd_en_s;
    logic        commit_s;
    logic        pending_s;
    logic [7:0]  ofs_s;
    logic [7:0]  rd_data_d;

    logic        ack_q;
    logic [7:0]  rd_q;
    logic [7:0]  daq_state_q;
    logic [31:0] dac_stage_q;
    logic [15:0] row_start_q;
    logic [15:0] row_end_q;
    logic [15:0] col_start_q;
    logic [15:0] col_end_q;
    logic [7:0]  pix_sel_q;
    logic [7:0]  power_on_wait_q;
    logic [7:0]  read_period_q;
    logic [7:0]  rst_period_q;
    logic [7:0]  clamp_period_q;

    // A combined WE+RE strobe is treated as a write; the read side is suppressed.
    assign strobe_s = RBCP_ACT & (RBCP_WE | RBCP_RE);
    assign in_win_s = (RBCP_ADDR[31:8] == BASE_ADDR[31:8]);
    assign ofs_s    = RBCP_ADDR[7:0];
    assign wr_en_s  = RBCP_ACT & RBCP_WE & in_win_s;
    assign rd_en_s  = RBCP_ACT & RBCP_RE & ~RBCP_WE & in_win_s;
    assign commit_s = wr_en_s & (ofs_s == OFS_DAC_COMMIT);

    // Register bank write decode.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            daq_state_q     <= 8'h00;
            dac_stage_q     <= 32'h0000_0000;
            row_start_q     <= 16'h0000;
            row_end_q       <= 16'h0000;
            col_start_q     <= 16'h0000;
            col_end_q       <= 16'h0000;
            pix_sel_q       <= 8'h00;
            power_on_wait_q <= 8'h00;
            read_period_q   <= 8'h00;
            rst_period_q    <= 8'h00;
            clamp_period_q  <= 8'h00;
        end else if (wr_en_s) begin
            case (ofs_s)
                OFS_DAQ_STATE:     daq_state_q        <= RBCP_WD;
                OFS_DAC_B3:        dac_stage_q[31:24] <= RBCP_WD;
                OFS_DAC_B2:        dac_stage_q[23:16] <= RBCP_WD;
                OFS_DAC_B1:        dac_stage_q[15:8]  <= RBCP_WD;
                OFS_DAC_B0:        dac_stage_q[7:0]   <= RBCP_WD;
                OFS_ROW_START_HI:  row_start_q[15:8]  <= RBCP_WD;
                OFS_ROW_START_LO:  row_start_q[7:0]   <= RBCP_WD;
                OFS_ROW_END_HI:    row_end_q[15:8]    <= RBCP_WD;
                OFS_ROW_END_LO:    row_end_q[7:0]     <= RBCP_WD;
                OFS_COL_START_HI:  col_start_q[15:8]  <= RBCP_WD;
                OFS_COL_START_LO:  col_start_q[7:0]   <= RBCP_WD;
                OFS_COL_END_HI:    col_end_q[15:8]    <= RBCP_WD;
                OFS_COL_END_LO:    col_end_q[7:0]     <= RBCP_WD;
                OFS_PIX_SEL:       pix_sel_q          <= RBCP_WD;
                OFS_POWER_ON_WAIT: power_on_wait_q    <= RBCP_WD;
                OFS_READ_PERIOD:   read_period_q      <= RBCP_WD;
                OFS_RST_PERIOD:    rst_period_q       <= RBCP_WD;
                OFS_CLAMP_PERIOD:  clamp_period_q     <= RBCP_WD;
                default: ;
            endcase
        end
    end

    // Read data mux; anything not selected reads as zero.
    always_comb begin
        rd_data_d = 8'h00;
        if (rd_en_s) begin
            case (ofs_s)
`ifdef RBCP_READBACK_EN
                OFS_DAQ_STATE:     rd_data_d = daq_state_q;
                OFS_DAC_B3:        rd_data_d = dac_stage_q[31:24];
                OFS_DAC_B2:        rd_data_d = dac_stage_q[23:16];
                OFS_DAC_B1:        rd_data_d = dac_stage_q[15:8];
                OFS_DAC_B0:        rd_data_d = dac_stage_q[7:0];
                OFS_ROW_START_HI:  rd_data_d = row_start_q[15:8];
                OFS_ROW_START_LO:  rd_data_d = row_start_q[7:0];
                OFS_ROW_END_HI:    rd_data_d = row_end_q[15:8];
                OFS_ROW_END_LO:    rd_data_d = row_end_q[7:0];
                OFS_COL_START_HI:  rd_data_d = col_start_q[15:8];
                OFS_COL_START_LO:  rd_data_d = col_start_q[7:0];
                OFS_COL_END_HI:    rd_data_d = col_end_q[15:8];
                OFS_COL_END_LO:    rd_data_d = col_end_q[7:0];
                OFS_PIX_SEL:       rd_data_d = pix_sel_q;
                OFS_POWER_ON_WAIT: rd_data_d = power_on_wait_q;
                OFS_READ_PERIOD:   rd_data_d = read_period_q;
                OFS_RST_PERIOD:    rd_data_d = rst_period_q;
                OFS_CLAMP_PERIOD:  rd_data_d = clamp_period_q;
`endif
                OFS_STATUS:        rd_data_d = status_byte(DAC_BUSY, pending_s);
                OFS_ID:            rd_data_d = ID_VALUE;
                default:           rd_data_d = 8'h00;
            endcase
        end else begin
            rd_data_d = 8'h00;
        end
    end

    // Acknowledge and read data, one cycle after the strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_q <= 1'b0;
            rd_q  <= 8'h00;
        end else begin
            ack_q <= strobe_s;
            rd_q  <= rd_data_d;
        end
    end

    rbcp_dac_commit u_dac_commit (
        .clk_i      (CLK),
        .rst_i      (RST),
        .commit_i   (commit_s),
        .dac_busy_i (DAC_BUSY),
        .stage_i    (dac_stage_q),
        .dac_data_o (DAC_DATA),
        .dac_we_o   (DAC_WE),
        .pending_o  (pending_s)
    );

    assign RBCP_ACK      = ack_q;
    assign RBCP_RD       = rd_q;
    assign DAQ_STATE     = daq_state_q;
    assign PIX_SEL       = pix_sel_q;
    assign POWER_ON_WAIT = power_on_wait_q;
    assign READ_PERIOD   = read_period_q;
    assign RST_PERIOD    = rst_period_q;
    assign CLAMP_PERIOD  = clamp_period_q;
    assign ROW_START     = row_start_q;
    assign ROW_END       = row_end_q;
    assign COL_START     = col_start_q;
    assign COL_END       = col_end_q;

endmodule

// File: tb/tb_rbcp_responder.sv
// Self-checking bench for rbcp_responder: vector table plus DAC commit sequences.
module tb_rbcp_responder;

    localparam logic [31:0] BASE = 32'h1234_5600;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RBCP_ACT = 1'b0;
    logic [31:0] RBCP_ADDR = 32'h0;
    logic        RBCP_WE = 1'b0;
    logic        RBCP_RE = 1'b0;
    logic [7:0]  RBCP_WD = 8'h00;
    logic        RBCP_ACK;
    logic [7:0]  RBCP_RD;
    logic        DAC_BUSY = 1'b0;
    logic [31:0] DAC_DATA;
    logic        DAC_WE;
    logic [7:0]  DAQ_STATE, PIX_SEL, POWER_ON_WAIT, READ_PERIOD, RST_PERIOD, CLAMP_PERIOD;
    logic [15:0] ROW_START, ROW_END, COL_START, COL_END;

    rbcp_responder #(.BASE_ADDR(BASE), .ID_VALUE(8'hC3)) dut (
        .CLK(CLK), .RST(RST), .RBCP_ACT(RBCP_ACT), .RBCP_ADDR(RBCP_ADDR),
        .RBCP_WE(RBCP_WE), .RBCP_RE(RBCP_RE), .RBCP_WD(RBCP_WD),
        .RBCP_ACK(RBCP_ACK), .RBCP_RD(RBCP_RD), .DAC_BUSY(DAC_BUSY),
        .DAC_DATA(DAC_DATA), .DAC_WE(DAC_WE), .DAQ_STATE(DAQ_STATE),
        .PIX_SEL(PIX_SEL), .POWER_ON_WAIT(POWER_ON_WAIT), .READ_PERIOD(READ_PERIOD),
        .RST_PERIOD(RST_PERIOD), .CLAMP_PERIOD(CLAMP_PERIOD),
        .ROW_START(ROW_START), .ROW_END(ROW_END), .COL_START(COL_START), .COL_END(COL_END)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        act;
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
    } vec_t;

    typedef struct {
        int         due;
        logic [7:0] rd;
    } sb_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   we_cnt = 0;
    int   we_cyc = -1;
    logic [31:0] we_data = 32'h0;
    sb_t  sb[$];
    vec_t vtab[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rb(input logic [7:0] v);
`ifdef RBCP_READBACK_EN
        return v;
`else
        return v & 8'h00;
`endif
    endfunction

    // Scoreboard / DAC_WE monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ack_missing: no ACK at cycle %0d expected", sb[0].due);
                void'(sb.pop_front());
            end
            if (RBCP_ACK) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", {31'd0, RBCP_ACK}, 32'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    check("ack_latency", cyc, e.due);
                    check("rbcp_rd", {24'd0, RBCP_RD}, {24'd0, e.rd});
                end
            end else begin
                check("rd_idle_zero", {24'd0, RBCP_RD}, 32'd0);
            end
        end
        if (DAC_WE) begin
            we_cnt++;
            we_cyc  = cyc;
            we_data = DAC_DATA;
        end
    end

    task automatic rbcp_op(input logic act, input logic we, input logic re,
                           input logic [31:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
        sb_t e;
        @(posedge CLK); #1;
        RBCP_ACT = act; RBCP_WE = we; RBCP_RE = re; RBCP_ADDR = addr; RBCP_WD = wd;
        if (act && (we || re)) begin
            e.due = cyc + 1;
            e.rd  = exp_rd;
            sb.push_back(e);
        end
        @(posedge CLK); #1;
        RBCP_ACT = 1'b0; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [7:0] d);
        rbcp_op(1'b1, 1'b1, 1'b0, BASE | {24'd0, ofs}, d, 8'h00);
    endtask

    task automatic rd(input logic [7:0] ofs, input logic [7:0] exp_rd);
        rbcp_op(1'b1, 1'b0, 1'b1, BASE | {24'd0, ofs}, 8'h00, exp_rd);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_daq_state"}, {24'd0, DAQ_STATE}, 32'd0);
        check({tag, "_dac_data"}, DAC_DATA, 32'd0);
        check({tag, "_dac_we"}, {31'd0, DAC_WE}, 32'd0);
        check({tag, "_ack"}, {31'd0, RBCP_ACK}, 32'd0);
        check({tag, "_rd"}, {24'd0, RBCP_RD}, 32'd0);
        check({tag, "_row_start"}, {16'd0, ROW_START}, 32'd0);
        check({tag, "_col_end"}, {16'd0, COL_END}, 32'd0);
        check({tag, "_pix_sel"}, {24'd0, PIX_SEL}, 32'd0);
        check({tag, "_clamp"}, {24'd0, CLAMP_PERIOD}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_cnt;
        int exp_cyc;

        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h00, 8'hA5, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h00, 8'h00, rb(8'hA5)});
        vtab.push_back('{1'b0, 1'b1, 1'b0, BASE | 32'h00, 8'h11, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE + 32'h100, 8'h5A, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE + 32'h100, 8'h00, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h06, 8'h11, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h07, 8'h22, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h08, 8'h33, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h09, 8'h44, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h0A, 8'h55, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h0B, 8'h66, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h0C, 8'h77, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h0D, 8'h88, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h0F, 8'hAA, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h10, 8'hBB, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h11, 8'hCC, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h12, 8'hDD, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h07, 8'h00, rb(8'h22)});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h0C, 8'h00, rb(8'h77)});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h12, 8'h00, rb(8'hDD)});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h14, 8'h00, 8'hC3});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h7F, 8'h00, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h15, 8'h00, 8'h00});
        vtab.push_back('{1'b1, 1'b1, 1'b0, BASE | 32'h14, 8'hFF, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h14, 8'h00, 8'hC3});
        vtab.push_back('{1'b1, 1'b1, 1'b1, BASE | 32'h0E, 8'h3C, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h0E, 8'h00, rb(8'h3C)});
        vtab.push_back('{1'b1, 1'b0, 1'b1, BASE | 32'h13, 8'h00, 8'h00});
        vtab.push_back('{1'b1, 1'b0, 1'b1, (BASE + 32'h100) | 32'h14, 8'h00, 8'h00});

        repeat (2) @(posedge CLK);
        #1;
        check_all_zero("reset");
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < vtab.size(); i++) begin
            rbcp_op(vtab[i].act, vtab[i].we, vtab[i].re, vtab[i].addr, vtab[i].wd, vtab[i].exp_rd);
        end
        repeat (2) @(posedge CLK);
        #1;
        check("daq_state", {24'd0, DAQ_STATE}, 32'h0000_00A5);
        check("row_start", {16'd0, ROW_START}, 32'h0000_1122);
        check("row_end", {16'd0, ROW_END}, 32'h0000_3344);
        check("col_start", {16'd0, COL_START}, 32'h0000_5566);
        check("col_end", {16'd0, COL_END}, 32'h0000_7788);
        check("pix_sel", {24'd0, PIX_SEL}, 32'h0000_003C);
        check("power_on_wait", {24'd0, POWER_ON_WAIT}, 32'h0000_00AA);
        check("read_period", {24'd0, READ_PERIOD}, 32'h0000_00BB);
        check("rst_period", {24'd0, RST_PERIOD}, 32'h0000_00CC);
        check("clamp_period", {24'd0, CLAMP_PERIOD}, 32'h0000_00DD);
        check("no_dac_we_yet", we_cnt, 0);

        // Immediate commit with the serializer idle.
        wr(8'h01, 8'h12); wr(8'h02, 8'h34); wr(8'h03, 8'h56); wr(8'h04, 8'h78);
        check("dac_data_pre_commit", DAC_DATA, 32'h0);
        wr(8'h05, 8'h00);
        exp_cyc = cyc;
        repeat (3) @(posedge CLK);
        #1;
        check("commit_we_count", we_cnt, 1);
        check("commit_we_cycle", we_cyc, exp_cyc);
        check("commit_we_data", we_data, 32'h1234_5678);
        check("commit_dac_data_hold", DAC_DATA, 32'h1234_5678);

        // Commit while busy, coalesced second commit, staging edited while pending.
        DAC_BUSY = 1'b1;
        base_cnt = we_cnt;
        wr(8'h01, 8'hDE); wr(8'h02, 8'hAD); wr(8'h03, 8'hBE); wr(8'h04, 8'hEF);
        wr(8'h05, 8'h00);
        wr(8'h05, 8'h00);
        rd(8'h13, 8'h03);
        wr(8'h01, 8'h00);
        repeat (20) @(posedge CLK);
        #1;
        check("busy_no_we", we_cnt, base_cnt);
        DAC_BUSY = 1'b0;
        exp_cyc = cyc + 1;
        repeat (4) @(posedge CLK);
        #1;
        check("pend_we_count", we_cnt, base_cnt + 1);
        check("pend_we_cycle", we_cyc, exp_cyc);
        check("pend_we_data", we_data, 32'hDEAD_BEEF);
        rd(8'h01, rb(8'h00));
        rd(8'h13, 8'h00);
        check("pend_dac_data_hold", DAC_DATA, 32'hDEAD_BEEF);

        // Reset while pending and with a strobe in flight.
        DAC_BUSY = 1'b1;
        base_cnt = we_cnt;
        wr(8'h05, 8'h00);
        @(posedge CLK); #1;
        RBCP_ACT = 1'b1; RBCP_RE = 1'b1; RBCP_ADDR = BASE | 32'h14;
        RST = 1'b1;
        sb.delete();
        @(posedge CLK); #1;
        RBCP_ACT = 1'b0; RBCP_RE = 1'b0;
        check_all_zero("in_reset");
        @(negedge CLK);
        RST = 1'b0;
        DAC_BUSY = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        check("post_reset_no_we", we_cnt, base_cnt);
        check_all_zero("post_reset");
        rd(8'h13, 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rbcp_responder.md
RBCP_RESPONDER -- requirements
Module: rbcp_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, RBCP window base; window = BASE_ADDR[31:8], offset = RBCP_ADDR[7:0].
REQ-002 Parameter ID_VALUE, default 8'hC3, read-only board ID byte.
REQ-003 CLK  input  1  system clock (100 MHz domain, same as SiTCP).
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 RBCP_ACT  input  1  RBCP transaction active.
REQ-006 RBCP_ADDR  input  32  access address.
REQ-007 RBCP_WE  input  1  write strobe, one-cycle pulse.
REQ-008 RBCP_RE  input  1  read strobe, one-cycle pulse.
REQ-009 RBCP_WD  input  8  write data.
REQ-010 RBCP_ACK  output  1  access acknowledge, one-cycle pulse.
REQ-011 RBCP_RD  output  8  read data, valid while RBCP_ACK high.
REQ-012 DAC_BUSY  input  1  DAC serializer busy.
REQ-013 DAC_DATA  output  32  DAC command word.
REQ-014 DAC_WE  output  1  DAC command strobe, one-cycle pulse.
REQ-015 DAQ_STATE, PIX_SEL, POWER_ON_WAIT, READ_PERIOD, RST_PERIOD, CLAMP_PERIOD  output  8 each  DUT/DAQ control.
REQ-016 ROW_START, ROW_END, COL_START, COL_END  output  16 each  readout window.

Function
REQ-017 Offset map: 0x00 DAQ_STATE; 0x01-0x04 DAC_DATA[31:24]..[7:0]; 0x05 DAC commit (write-only, data ignored); 0x06/0x07 ROW_START hi/lo; 0x08/0x09 ROW_END; 0x0A/0x0B COL_START; 0x0C/0x0D COL_END; 0x0E PIX_SEL; 0x0F POWER_ON_WAIT; 0x10 READ_PERIOD; 0x11 RST_PERIOD; 0x12 CLAMP_PERIOD; 0x13 status (RO: bit0 DAC_BUSY, bit1 commit pending, others 0); 0x14 ID_VALUE (RO).
REQ-018 Strobes act only when RBCP_ACT=1 and address is in window; otherwise ignored for register effect.
REQ-019 Every strobe with RBCP_ACT=1 gets exactly one RBCP_ACK, the cycle after the strobe (latency 1), in-window or not.
REQ-020 Out-of-window or unmapped reads return 8'h00; unmapped or RO writes are acknowledged and discarded.
REQ-021 RBCP_RD = 8'h00 whenever RBCP_ACK=0.
REQ-022 RBCP_WE and RBCP_RE in same cycle: write performed, read suppressed, single ACK with RD=8'h00.
REQ-023 Register writes update outputs the cycle after the strobe; no partial-update protection for multi-byte fields.
REQ-024 DAC commit FSM states IDLE, PEND, PULSE: commit write in IDLE -> PULSE if DAC_BUSY=0, else PEND; PEND -> PULSE when DAC_BUSY=0; PULSE -> IDLE after one cycle with DAC_WE=1.
REQ-025 DAC_DATA snapshot taken at commit and held stable from DAC_WE until next commit; writes to 0x01-0x04 during PEND/PULSE change only the staging bytes.
REQ-026 Commit write while in PEND or PULSE is acknowledged and coalesced (no extra DAC_WE).

Reset
REQ-027 On RST: all register outputs 0, DAC_DATA 0, DAC_WE 0, RBCP_ACK 0, RBCP_RD 0, FSM IDLE, pending cleared.
REQ-028 RST asserted mid-transaction or in PEND drops the pending ACK and commit; no DAC_WE after release until a new commit.

Configuration
REQ-029 Macro RBCP_READBACK_EN: defined -> offsets 0x00-0x04, 0x06-0x12 read back current values; undefined -> those reads return 8'h00, only 0x13 and 0x14 readable; write behaviour identical.

Structure
REQ-030 Shared package cpv3_rbcp_pkg holds offset constants, status bit positions, FSM state enum.
REQ-031 One sub-module rbcp_dac_commit implements REQ-024..026; decode and register bank stay in the top.

Verification
REQ-032 Write 0xA5 to 0x00, read 0x00 -> ACK one cycle after each strobe, DAQ_STATE=0xA5, RD=0xA5 (8'h00 without RBCP_READBACK_EN).
REQ-033 Write 0x12,0x34,0x56,0x78 to 0x01-0x04, commit with DAC_BUSY=0 -> single DAC_WE pulse, DAC_DATA=32'h12345678.
REQ-034 DAC_BUSY=1, commit twice, drop DAC_BUSY after 20 cycles -> status bit1=1 while waiting, exactly one DAC_WE, the cycle after DAC_BUSY falls.
REQ-035 Read 0x14 and 0x7F; read with RBCP_ADDR=BASE_ADDR+32'h100 -> RD 0xC3, 0x00, 0x00, all ACKed.
REQ-036 Simultaneous WE/RE to 0x0E with WD=0x3C -> one ACK, RD=0x00, PIX_SEL=0x3C.
REQ-037 Commit in PEND then RST pulse, release, DAC_BUSY=0 -> no DAC_WE, all outputs 0.
